// File: rtl/u_rf.sv
// ============================================================================
// u_rf -- integer register file (XLEN x NREG), two read ports, one write port
//
// Purpose:
//   Architectural register file on the far side of the u_exe rf interface.
//   The array is plain non-reset storage, as an SRAM macro would be. After
//   every reset an init FSM scrubs entries 1..NREG-1 to zero, one per cycle.
//   rf_ready goes high once the scrub is done. Entry 0 is x0. It is never
//   stored and always reads as zero.
//
// Ports:
//   clk       in   1     clock, rising edge
//   rstn      in   1     asynchronous active-low reset
//   rf_rs1_a  in   AW    read port 1 address
//   rf_rs2_a  in   AW    read port 2 address
//   rf_rs1_o  out  XLEN  read port 1 data (combinational)
//   rf_rs2_o  out  XLEN  read port 2 data (combinational)
//   rf_rd_e   in   1     write enable
//   rf_rd_a   in   AW    write address
//   rf_rd_i   in   XLEN  write data
//   rf_ready  out  1     scrub done; reads valid, writes accepted
//   rf_wr_cnt out  16    committed writes to x1..x(NREG-1), wraps
//
// Configuration:
//   RF_BYPASS_EN  defined   -> write-first: a read of the register being
//                              written this cycle returns rf_rd_i
//                 undefined -> read-first: a read returns the old contents
// ============================================================================
`timescale 1ns/1ps
module u_rf #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [AW-1:0]   rf_rs1_a,
    input  logic [AW-1:0]   rf_rs2_a,
    output logic [XLEN-1:0] rf_rs1_o,
    output logic [XLEN-1:0] rf_rs2_o,
    input  logic            rf_rd_e,
    input  logic [AW-1:0]   rf_rd_a,
    input  logic [XLEN-1:0] rf_rd_i,
    output logic            rf_ready,
    output logic [15:0]     rf_wr_cnt
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic            r_ready;
    logic [15:0]     r_wr_cnt;
    logic [XLEN-1:0] r_mem [NREG];

    logic            w_run;
    logic            w_wr;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;

    assign w_run = (r_state == S_RUN);
    // Accepted write: only in RUN and never to x0.
    assign w_wr  = w_run && rf_rd_e && (rf_rd_a != '0);

    // Control FSM. rf_ready is registered alongside the state. It rises on
    // the same edge that scrubs the last entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_INIT;
            r_idx    <= AW'(1);
            r_ready  <= 1'b0;
            r_wr_cnt <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_idx == AW'(NREG-1)) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                S_RUN: begin
                    if (w_wr)
                        r_wr_cnt <= r_wr_cnt + 16'd1;
                end
                default: begin
                    r_state <= S_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset, like an SRAM. The scrub writes zeros through the
    // same port that RUN writes use.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT)
            r_mem[r_idx] <= '0;
        else if (w_wr)
            r_mem[rf_rd_a] <= rf_rd_i;
    end

    // Read ports. They are forced to zero during INIT and for x0. Entry 0 is
    // never written, so it must never be read either.
    always_comb begin
        w_rs1 = '0;
        w_rs2 = '0;
        if (w_run && (rf_rs1_a != '0)) w_rs1 = r_mem[rf_rs1_a];
        if (w_run && (rf_rs2_a != '0)) w_rs2 = r_mem[rf_rs2_a];
`ifdef RF_BYPASS_EN
        // Write-first. w_wr already excludes INIT and x0.
        if (w_wr && (rf_rd_a == rf_rs1_a)) w_rs1 = rf_rd_i;
        if (w_wr && (rf_rd_a == rf_rs2_a)) w_rs2 = rf_rd_i;
`endif
    end

    assign rf_rs1_o  = w_rs1;
    assign rf_rs2_o  = w_rs2;
    assign rf_ready  = r_ready;
    assign rf_wr_cnt = r_wr_cnt;

endmodule

// File: tb/tb_u_rf.sv
`timescale 1ns/1ps
module tb_u_rf;

    logic        clk;
    logic        rstn;
    logic [4:0]  rf_rs1_a, rf_rs2_a, rf_rd_a;
    logic [31:0] rf_rs1_o, rf_rs2_o, rf_rd_i;
    logic        rf_rd_e;
    logic        rf_ready;
    logic [15:0] rf_wr_cnt;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    u_rf #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rf_rs1_a (rf_rs1_a),
        .rf_rs2_a (rf_rs2_a),
        .rf_rs1_o (rf_rs1_o),
        .rf_rs2_o (rf_rs2_o),
        .rf_rd_e  (rf_rd_e),
        .rf_rd_a  (rf_rd_a),
        .rf_rd_i  (rf_rd_i),
        .rf_ready (rf_ready),
        .rf_wr_cnt(rf_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven on the falling edge and outputs are sampled #1 later.

    task automatic test_reset();
        rstn = 1'b0; rf_rd_e = 1'b0; rf_rd_a = '0; rf_rd_i = '0;
        rf_rs1_a = 5'd5; rf_rs2_a = 5'd5;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 31; c++) begin
            sb.push_back('{"rst_ready_low", 32'd0});
            sb.push_back('{"rst_rs1_zero", 32'd0});
            #1;
            e = sb.pop_front(); n_cmp++;
            if ({31'd0, rf_ready} !== e.v) begin
                n_fail++; $display("FAIL %s c=%0d: got %h want %h", e.nm, c, rf_ready, e.v);
            end
            e = sb.pop_front(); n_cmp++;
            if (rf_rs1_o !== e.v) begin
                n_fail++; $display("FAIL %s c=%0d: got %h want %h", e.nm, c, rf_rs1_o, e.v);
            end
            @(negedge clk);
        end
        sb.push_back('{"rst_ready_high", 32'd1});
        sb.push_back('{"rst_rs1_scrubbed", 32'd0});
        sb.push_back('{"rst_cnt", 32'd0});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, rf_ready} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_ready, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if (rf_rs1_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs1_o, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if ({16'd0, rf_wr_cnt} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_wr_cnt, e.v);
        end
    endtask

    task automatic test_write();
        @(negedge clk);
        rf_rd_e = 1'b1; rf_rd_a = 5'd7; rf_rd_i = 32'hDEADBEEF;
        @(negedge clk);
        rf_rd_e = 1'b0; rf_rs1_a = 5'd7; rf_rs2_a = 5'd7;
        sb.push_back('{"wr_rs1", 32'hDEADBEEF});
        sb.push_back('{"wr_rs2", 32'hDEADBEEF});
        sb.push_back('{"wr_cnt", 32'd1});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (rf_rs1_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs1_o, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if (rf_rs2_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs2_o, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if ({16'd0, rf_wr_cnt} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_wr_cnt, e.v);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        rf_rd_e = 1'b1; rf_rd_a = 5'd0; rf_rd_i = 32'h12345678; rf_rs1_a = 5'd0;
        sb.push_back('{"x0_now", 32'd0});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (rf_rs1_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs1_o, e.v);
        end
        @(negedge clk);
        rf_rd_e = 1'b0;
        sb.push_back('{"x0_after", 32'd0});
        sb.push_back('{"x0_cnt", 32'd1});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (rf_rs1_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs1_o, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if ({16'd0, rf_wr_cnt} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_wr_cnt, e.v);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        rf_rd_e = 1'b1; rf_rd_a = 5'd3; rf_rd_i = 32'hA5A5A5A5; rf_rs2_a = 5'd3;
`ifdef RF_BYPASS_EN
        sb.push_back('{"same_cyc", 32'hA5A5A5A5});
`else
        sb.push_back('{"same_cyc", 32'd0});
`endif
        #1;
        e = sb.pop_front(); n_cmp++;
        if (rf_rs2_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs2_o, e.v);
        end
        @(negedge clk);
        rf_rd_e = 1'b0;
        sb.push_back('{"same_next", 32'hA5A5A5A5});
        sb.push_back('{"same_cnt", 32'd2});
        #1;
        e = sb.pop_front(); n_cmp++;
        if (rf_rs2_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs2_o, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if ({16'd0, rf_wr_cnt} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_wr_cnt, e.v);
        end
    endtask

    task automatic test_mid_reset();
        // Put nonzero data in x31, which the scrub reaches last.
        @(negedge clk);
        rf_rd_e = 1'b1; rf_rd_a = 5'd31; rf_rd_i = 32'hFFFFFFFF;
        @(negedge clk);
        rf_rd_e = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        sb.push_back('{"mid_async_ready", 32'd0});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, rf_ready} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_ready, e.v);
        end
        @(negedge clk);
        rstn = 1'b1;
        rf_rd_e = 1'b1; rf_rd_a = 5'd9; rf_rd_i = 32'h99999999; rf_rs1_a = 5'd31;
        for (int c = 0; c < 31; c++) begin
            sb.push_back('{"mid_ready_low", 32'd0});
            sb.push_back('{"mid_init_rs1", 32'd0});
            sb.push_back('{"mid_init_cnt", 32'd0});
            #1;
            e = sb.pop_front(); n_cmp++;
            if ({31'd0, rf_ready} !== e.v) begin
                n_fail++; $display("FAIL %s c=%0d: got %h want %h", e.nm, c, rf_ready, e.v);
            end
            e = sb.pop_front(); n_cmp++;
            if (rf_rs1_o !== e.v) begin
                n_fail++; $display("FAIL %s c=%0d: got %h want %h", e.nm, c, rf_rs1_o, e.v);
            end
            e = sb.pop_front(); n_cmp++;
            if ({16'd0, rf_wr_cnt} !== e.v) begin
                n_fail++; $display("FAIL %s c=%0d: got %h want %h", e.nm, c, rf_wr_cnt, e.v);
            end
            @(negedge clk);
        end
        rf_rd_e = 1'b0; rf_rs2_a = 5'd9;
        sb.push_back('{"mid_ready_high", 32'd1});
        sb.push_back('{"mid_x31_lost", 32'd0});
        sb.push_back('{"mid_x9_dropped", 32'd0});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({31'd0, rf_ready} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_ready, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if (rf_rs1_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs1_o, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if (rf_rs2_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs2_o, e.v);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 65534; i++) begin
            @(negedge clk);
            rf_rd_e = 1'b1; rf_rd_a = 5'd1; rf_rd_i = i;
        end
        @(negedge clk);
        rf_rd_e = 1'b0;
        sb.push_back('{"wrap_pre", 32'h0000FFFE});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({16'd0, rf_wr_cnt} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_wr_cnt, e.v);
        end
        @(negedge clk);
        rf_rd_e = 1'b1; rf_rd_i = 32'hCAFE0001;
        @(negedge clk);
        rf_rd_i = 32'hCAFE0002;
        @(negedge clk);
        rf_rd_e = 1'b0; rf_rs1_a = 5'd1;
        sb.push_back('{"wrap_cnt", 32'd0});
        sb.push_back('{"wrap_x1", 32'hCAFE0002});
        #1;
        e = sb.pop_front(); n_cmp++;
        if ({16'd0, rf_wr_cnt} !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_wr_cnt, e.v);
        end
        e = sb.pop_front(); n_cmp++;
        if (rf_rs1_o !== e.v) begin
            n_fail++; $display("FAIL %s: got %h want %h", e.nm, rf_rs1_o, e.v);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_x0();
        test_same_cycle();
        test_mid_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
